// File: rtl/activity_monitor.sv
// activity_monitor
//   Merges masked per-source activity strobes into one stretched blink_en level
//   for the activity-LED blinker, with a saturating event counter and sticky
//   per-source flags for status readback.
//   Optional: define ACTMON_SYNC_EN to put a 2-flop synchronizer on every act_i bit,
//   which allows act_i to be asynchronous and adds 2 cycles to every act_i-related latency.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no recent activity, blink_en low, timer parked at HOLD
//   ST_ACTIVE | a masked source is active this cycle, timer held at HOLD
//   ST_HOLD   | activity stopped, timer counting down to 0 before IDLE

module activity_monitor #(
    parameter int unsigned NSRC  = 4,
    parameter logic [23:0] HOLD  = 24'h3F_FFFF,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NSRC-1:0]  act_i,
    input  logic [NSRC-1:0]  act_mask_i,
    input  logic             cnt_clr_i,
    output logic             blink_en,
    output logic [NSRC-1:0]  act_src_o,
    output logic [CNT_W-1:0] event_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state, state_nxt;
    logic [23:0]     timer, timer_nxt;
    logic [NSRC-1:0] act_s;
    logic [NSRC-1:0] act_q;
    logic            hit;
    logic            rise;

`ifdef ACTMON_SYNC_EN
    logic [NSRC-1:0] sync_q1, sync_q2;

    // Two-flop synchronizer so act_i may come from another clock domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= act_i;
            sync_q2 <= sync_q1;
        end
    end

    assign act_s = sync_q2;
`else
    assign act_s = act_i;
`endif

    assign hit  = |(act_s & act_mask_i);
    assign rise = |(act_s & ~act_q & act_mask_i);

    // Previous-cycle activity, unmasked, so a mask change never fakes a rising edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) act_q <= '0;
        else         act_q <= act_s;
    end

    // Next-state and hold-timer logic; timer==0 is tested before decrementing.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            ST_IDLE: begin
                timer_nxt = HOLD;
                if (hit) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                timer_nxt = HOLD;
                if (!hit) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (hit) begin
                    state_nxt = ST_ACTIVE;
                    timer_nxt = HOLD;
                end else if (timer == 24'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer - 24'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = HOLD;
            end
        endcase
    end

    // State, timer and the registered blink enable (high whenever not heading to IDLE).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            timer    <= HOLD;
            blink_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            blink_en <= (state_nxt != ST_IDLE);
        end
    end

    // Sticky per-source flags for the current burst, wiped as the burst ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                     act_src_o <= '0;
        else if (state != ST_IDLE && state_nxt == ST_IDLE) act_src_o <= '0;
        else                                             act_src_o <= act_src_o | (act_s & act_mask_i);
    end

    // Saturating event counter; clear wins over a coincident rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          event_cnt_o <= '0;
        else if (cnt_clr_i)                   event_cnt_o <= '0;
        else if (rise && event_cnt_o != CNT_MAX) event_cnt_o <= event_cnt_o + 1'b1;
    end

endmodule
